// File: rtl/cchw_pkg.sv
// Shared colour types for the visualiser path: packed RGB pixel and the six
// hue sectors of the HSV colour wheel.
package cchw_pkg;

  localparam int CCHW_C      = 8;
  localparam int HUE_SECTORS = 6;

  typedef struct packed {
    logic [CCHW_C-1:0] r;
    logic [CCHW_C-1:0] g;
    logic [CCHW_C-1:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    SEC_R_Y = 3'd0,
    SEC_Y_G = 3'd1,
    SEC_G_C = 3'd2,
    SEC_C_B = 3'd3,
    SEC_B_M = 3'd4,
    SEC_M_R = 3'd5
  } hue_sector_e;

endpackage

// File: rtl/hue_sector_mux.sv
// Combinational HSV-to-RGB sector selection (saturation fixed at 1).
module hue_sector_mux
  import cchw_pkg::*;
(
  input  hue_sector_e         i_sector,
  input  logic [CCHW_C-1:0]   i_v,
  input  logic [CCHW_C-1:0]   i_q,
  input  logic [CCHW_C-1:0]   i_t,
  output rgb_t                o_rgb
);

  always_comb begin
    o_rgb = '0;
    // Codes 6 and 7 cannot come out of hue*6 and fall through to black.
    if (int'(i_sector) < HUE_SECTORS) begin
      case (i_sector)
        SEC_R_Y: o_rgb = '{r: i_v,  g: i_t,  b: '0 };
        SEC_Y_G: o_rgb = '{r: i_q,  g: i_v,  b: '0 };
        SEC_G_C: o_rgb = '{r: '0,   g: i_v,  b: i_t};
        SEC_C_B: o_rgb = '{r: '0,   g: i_q,  b: i_v};
        SEC_B_M: o_rgb = '{r: i_t,  g: '0,   b: i_v};
        SEC_M_R: o_rgb = '{r: i_v,  g: '0,   b: i_q};
        default: o_rgb = '0;
      endcase
    end
  end

endmodule

// File: rtl/hue_to_rgb.sv
// Three-stage hue/amplitude to packed RGB converter with downstream back-pressure.
// Optional square-law amplitude when HUE_TO_RGB_GAMMA_EN is defined.
module hue_to_rgb
  import cchw_pkg::*;
#(
  parameter int D = 10,
  parameter int C = CCHW_C
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D-1:0]   hue_i,
  input  logic [D-1:0]   value_i,
  input  logic           start,
  output logic           ready_o,
  input  logic           ready_i,
  output logic [3*C-1:0] rgb_o,
  output logic           data_v
);

  logic           w_stall;
  logic [D+2:0]   w_h6;
  logic [C-1:0]   w_v_lin;
  logic [C-1:0]   w_v0;
  logic           w_unused_lsbs;
  logic [C+D-1:0] w_q_prod;
  logic [C+D-1:0] w_t_prod;
  rgb_t           w_rgb;

  logic           r_valid0;
  hue_sector_e    r_sector0;
  logic [D-1:0]   r_f0;
  logic [C-1:0]   r_val0;

  logic           r_valid1;
  hue_sector_e    r_sector1;
  logic [C-1:0]   r_q1;
  logic [C-1:0]   r_t1;
  logic [C-1:0]   r_val1;

  assign w_stall = data_v & ~ready_i;
  assign ready_o = ~w_stall;

  assign w_h6          = {3'b000, hue_i} * (D+3)'(6);
  assign w_v_lin       = value_i[D-1:D-C];
  assign w_unused_lsbs = ^value_i[D-C-1:0];

`ifdef HUE_TO_RGB_GAMMA_EN
  logic [2*C-1:0] w_v_sq;
  assign w_v_sq = {{C{1'b0}}, w_v_lin} * {{C{1'b0}}, w_v_lin};
  assign w_v0   = C'(w_v_sq >> C);
`else
  assign w_v0   = w_v_lin;
`endif

  // ~f is exactly (2^D-1-f) for a D-bit f.
  assign w_q_prod = {{D{1'b0}}, r_val0} * {{C{1'b0}}, ~r_f0};
  assign w_t_prod = {{D{1'b0}}, r_val0} * {{C{1'b0}}, r_f0};

  hue_sector_mux u_mux (
    .i_sector (r_sector1),
    .i_v      (r_val1),
    .i_q      (r_q1),
    .i_t      (r_t1),
    .o_rgb    (w_rgb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      data_v   <= 1'b0;
      rgb_o    <= '0;
    end else if (!w_stall) begin
      r_valid0 <= start;
      r_valid1 <= r_valid0;
      data_v   <= r_valid1;
      if (r_valid1) begin
        rgb_o <= w_rgb;
      end
    end
  end

  // Data path carries no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_sector0 <= hue_sector_e'(w_h6[D+2:D]);
      r_f0      <= w_h6[D-1:0];
      r_val0    <= w_v0;
      r_sector1 <= r_sector0;
      r_q1      <= C'(w_q_prod >> D);
      r_t1      <= C'(w_t_prod >> D);
      r_val1    <= r_val0;
    end
  end

endmodule

// File: tb/tb_hue_to_rgb.sv
// Directed cycle-exact bench for hue_to_rgb (D=10, C=8); honours HUE_TO_RGB_GAMMA_EN.
module tb_hue_to_rgb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hue_i;
  logic [9:0]  value_i;
  logic        start;
  logic        ready_o;
  logic        ready_i;
  logic [23:0] rgb_o;
  logic        data_v;

  int n_checks = 0;
  int n_errors = 0;

`ifdef HUE_TO_RGB_GAMMA_EN
  localparam logic [23:0] E_H0    = 24'hFE0000;
  localparam logic [23:0] E_H341  = 24'h00FE00;
  localparam logic [23:0] E_H512  = 24'h00FDFE;
  localparam logic [23:0] E_H1023 = 24'hFE0001;
  localparam logic [23:0] E_H170  = 24'hFEFD00;
  localparam logic [23:0] E_HALF  = 24'h400000;
`else
  localparam logic [23:0] E_H0    = 24'hFF0000;
  localparam logic [23:0] E_H341  = 24'h00FF00;
  localparam logic [23:0] E_H512  = 24'h00FEFF;
  localparam logic [23:0] E_H1023 = 24'hFF0001;
  localparam logic [23:0] E_H170  = 24'hFFFE00;
  localparam logic [23:0] E_HALF  = 24'h800000;
`endif

  hue_to_rgb #(.D(10), .C(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .hue_i   (hue_i),
    .value_i (value_i),
    .start   (start),
    .ready_o (ready_o),
    .ready_i (ready_i),
    .rgb_o   (rgb_o),
    .data_v  (data_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic expect_out(input string tag, input logic [23:0] exp);
    check({tag, "_v"}, {31'd0, data_v}, 32'd1);
    check({tag, "_rgb"}, {8'd0, rgb_o}, {8'd0, exp});
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_v"}, {31'd0, data_v}, 32'd0);
  endtask

  // Present one request and step to the next falling edge.
  task automatic offer(input logic [9:0] h, input logic [9:0] v);
    hue_i   = h;
    value_i = v;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready_i = 1'b1; hue_i = '0; value_i = '0;
    repeat (2) @(negedge clk);
    check("rst_data_v", {31'd0, data_v}, 32'd0);
    check("rst_rgb", {8'd0, rgb_o}, 32'd0);
    check("rst_ready_o", {31'd0, ready_o}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // ready_i low with nothing valid leaves ready_o high
    ready_i = 1'b0;
    #1 check("idle_ready_o", {31'd0, ready_o}, 32'd1);
    @(negedge clk);
    ready_i = 1'b1;

    // Test 1: latency of exactly three edges
    offer(10'd0, 10'd1023);
    @(negedge clk);
    expect_idle("t1_early");
    @(negedge clk);
    expect_out("t1_red", E_H0);
    @(negedge clk);
    expect_idle("t1_after");

    // Test 2: back-to-back, one result per cycle
    offer(10'd341, 10'd1023);
    offer(10'd512, 10'd1023);
    offer(10'd1023, 10'd1023);
    expect_out("t2_h341", E_H341);
    @(negedge clk);
    expect_out("t2_h512", E_H512);
    @(negedge clk);
    expect_out("t2_h1023", E_H1023);
    @(negedge clk);
    expect_idle("t2_after");

    // Test 3: orange, then zero amplitude
    offer(10'd170, 10'd1023);
    offer(10'd700, 10'd0);
    @(negedge clk);
    expect_out("t3_h170", E_H170);
    @(negedge clk);
    expect_out("t3_black", 24'h000000);
    @(negedge clk);

    // Test 6: half amplitude (linear or square-law)
    offer(10'd0, 10'd512);
    @(negedge clk);
    @(negedge clk);
    expect_out("t6_half", E_HALF);
    @(negedge clk);

    // Test 4: stall with three results in flight
    offer(10'd0, 10'd1023);
    offer(10'd341, 10'd1023);
    offer(10'd512, 10'd1023);
    expect_out("t4_first", E_H0);
    ready_i = 1'b0;
    #1 check("t4_ready_o_comb", {31'd0, ready_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        hue_i = 10'd1023; value_i = 10'd1023; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      expect_out($sformatf("t4_hold%0d", i), E_H0);
      check($sformatf("t4_ready%0d", i), {31'd0, ready_o}, 32'd0);
    end
    start = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    expect_out("t4_second", E_H341);
    @(negedge clk);
    expect_out("t4_third", E_H512);
    @(negedge clk);
    expect_idle("t4_drop_a");
    @(negedge clk);
    expect_idle("t4_drop_b");

    // Test 5: reset discards two in-flight results
    offer(10'd0, 10'd1023);
    offer(10'd512, 10'd1023);
    rst = 1'b1;
    @(negedge clk);
    check("t5_data_v", {31'd0, data_v}, 32'd0);
    check("t5_rgb", {8'd0, rgb_o}, 32'd0);
    check("t5_ready_o", {31'd0, ready_o}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      expect_idle($sformatf("t5_stale%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
